// File: rtl/decoder_pkg.sv
// Shared definitions for the round-robin decoder arbiter: FSM state encoding
// and requester geometry.
package decoder_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_rr_arbiter_dec.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder_rr_arbiter_dec (
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    input  logic       i_en,
    output logic [7:0] o_d
);

    // Drive the single output selected by {c,b,a} when enabled.
    always_comb begin
        o_d = 8'h00;
        if (i_en) begin
            o_d[{i_c, i_b, i_a}] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter over 8 requesters with a registered grant index that
// drives a 3-to-8 decoder to form the one-hot grant.
// Optional feature: define DECODER_ARB_TIMEOUT_EN to force release of a grant
// after HOLD_MAX cycles, signalled by a one-cycle timeout pulse.
module decoder_rr_arbiter
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic       sel_a,
    output logic       sel_b,
    output logic       sel_c,
    output logic       busy,
    output logic       timeout
);

    state_e           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_pick;
    logic             w_rel_normal;
    logic             w_hold_hit;
    logic             w_release;

    // First set request at or above p, wrapping 7->0; index arithmetic wraps mod 8.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = p + IDX_W'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Priority search and release conditions for the current grant.
    always_comb begin
        w_pick       = rr_pick(req, r_ptr);
        w_rel_normal = !en || done || !req[r_idx];
        w_release    = w_rel_normal || w_hold_hit;
    end

`ifdef DECODER_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    assign w_hold_hit = (r_state == ST_GRANT) && (r_cnt == CNT_W'(HOLD_MAX - 1));
    assign timeout    = r_timeout;

    // Count elapsed GRANT cycles; pulse timeout only when the limit alone ends a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_hold_hit && !w_rel_normal;
            if (r_state == ST_GRANT && !w_release) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end
`else
    logic w_unused_hold;

    assign w_hold_hit    = 1'b0;
    assign timeout       = 1'b0;
    assign w_unused_hold = ^HOLD_MAX;
`endif

    // Arbitration FSM: grant from IDLE, release from GRANT and advance the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en && (req != 8'h00)) begin
                        r_state <= ST_GRANT;
                        r_idx   <= w_pick;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_idx + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == ST_GRANT);
    assign sel_a = r_idx[0];
    assign sel_b = r_idx[1];
    assign sel_c = r_idx[2];

    decoder_rr_arbiter_dec u_dec (
        .i_a  (sel_a),
        .i_b  (sel_b),
        .i_c  (sel_c),
        .i_en (busy),
        .o_d  (gnt)
    );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter: vector table, rotation,
// async reset, enable handling and hold-limit behaviour.
module tb_decoder_rr_arbiter;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       busy;
        logic       tmo;
    } exp_t;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       busy;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       sel_a;
    logic       sel_b;
    logic       sel_c;
    logic       busy;
    logic       timeout;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    vec_t tbl[14];

    decoder_rr_arbiter #(
        .HOLD_MAX (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel_a   (sel_a),
        .sel_b   (sel_b),
        .sel_c   (sel_c),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired before completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [7:0] g, input logic [2:0] i, input logic b,
                                input logic t);
        exp_t x;
        x.gnt  = g;
        x.idx  = i;
        x.busy = b;
        x.tmo  = t;
        return x;
    endfunction

    task automatic compare(input string name, input exp_t x);
        n_checks++;
        if ({gnt, sel_c, sel_b, sel_a, busy, timeout} !== {x.gnt, x.idx, x.busy, x.tmo}) begin
            n_errors++;
            $display("FAIL %s: got gnt=%h sel=%0d busy=%b tmo=%b, want gnt=%h sel=%0d busy=%b tmo=%b",
                     name, gnt, {sel_c, sel_b, sel_a}, busy, timeout,
                     x.gnt, x.idx, x.busy, x.tmo);
        end
    endtask

    // One clock: drive at negedge, queue expectation, check just after posedge.
    task automatic cyc(input string name, input logic e, input logic [7:0] r, input logic d,
                       input exp_t x);
        exp_t got;
        @(negedge clk);
        en   = e;
        req  = r;
        done = d;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got 0 entries, want 1", name);
        end else begin
            got = sb.pop_front();
            compare(name, got);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compare(name, mk(8'h00, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        req      = 8'h00;
        done     = 1'b0;

        //           en    req    done  gnt    idx   busy
        tbl[0]  = '{1'b1, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1};
        tbl[1]  = '{1'b1, 8'h81, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1};
        tbl[3]  = '{1'b1, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1};
        tbl[4]  = '{1'b1, 8'h01, 1'b0, 8'h00, 3'd7, 1'b0};
        tbl[5]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd7, 1'b0};
        tbl[6]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd7, 1'b0};
        tbl[7]  = '{1'b1, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1};
        tbl[8]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[9]  = '{1'b1, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1};
        tbl[10] = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0};
        tbl[11] = '{1'b1, 8'hFF, 1'b0, 8'h10, 3'd4, 1'b1};
        tbl[12] = '{1'b1, 8'hFF, 1'b1, 8'h00, 3'd4, 1'b0};
        tbl[13] = '{1'b1, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1};

        do_reset("reset_state");

        for (int i = 0; i < 14; i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].en, tbl[i].req, tbl[i].done,
                mk(tbl[i].gnt, tbl[i].idx, tbl[i].busy, 1'b0));
        end

        // Reset mid-grant to requester 5 must clear outputs without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        #1;
        compare("async_reset", mk(8'h00, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_reset_grant", 1'b1, 8'h30, 1'b0, mk(8'h10, 3'd4, 1'b1, 1'b0));

        // Full rotation with one IDLE cycle between grants.
        do_reset("reset_rot");
        for (int k = 0; k < 9; k++) begin
            cyc($sformatf("rot_grant%0d", k), 1'b1, 8'hFF, 1'b0,
                mk(8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0));
            cyc($sformatf("rot_idle%0d", k), 1'b1, 8'hFF, 1'b1,
                mk(8'h00, 3'(k % 8), 1'b0, 1'b0));
        end

        // Long hold with done never asserted.
        do_reset("reset_hold");
`ifdef DECODER_ARB_TIMEOUT_EN
        for (int c = 0; c < 10; c++) begin
            if ((c % 5) < 4) begin
                cyc($sformatf("hold%0d", c), 1'b1, 8'h04, 1'b0, mk(8'h04, 3'd2, 1'b1, 1'b0));
            end else begin
                cyc($sformatf("hold_tmo%0d", c), 1'b1, 8'h04, 1'b0,
                    mk(8'h00, 3'd2, 1'b0, 1'b1));
            end
        end
`else
        for (int c = 0; c < 20; c++) begin
            cyc($sformatf("hold%0d", c), 1'b1, 8'h04, 1'b0, mk(8'h04, 3'd2, 1'b1, 1'b0));
        end
`endif
        cyc("hold_en_off", 1'b0, 8'h04, 1'b0, mk(8'h00, 3'd2, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
